// File: rtl/uart_rx_engine_pkg.sv
// rtl/uart_rx_engine_pkg.sv - shared UART receive constants, FSM state encodings and parity helper
package uart_rx_engine_pkg;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_CLKS_PER_BIT_DEFAULT = 868;

    typedef logic [2:0] rx_state_t;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_PARITY    = 3'd3;
    localparam logic [2:0] ST_STOP      = 3'd4;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

    // Parity bit a transmitter would send for this byte (odd=1 selects odd sense)
    function automatic logic parity_of(input logic [UART_DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer for asynchronous inputs, resets to a chosen level
module uart_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture; both stages reset to the idle level so no false edge leaves reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_engine.sv
// rtl/uart_rx_engine.sv - UART 8N1 receive engine with valid/ready output; UART_RX_PARITY_EN adds a parity bit
module uart_rx_engine
    import uart_rx_engine_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
    parameter int ODD_PARITY   = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rxd,
    input  logic                      rx_enable,
    output logic [UART_DATA_BITS-1:0] rx_data,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    output logic                      frame_err,
    output logic                      parity_err,
    output logic                      overrun,
    output logic                      busy
);

    localparam int             PW    = $clog2(CLKS_PER_BIT);
    localparam logic [PW-1:0]  HALF  = PW'(CLKS_PER_BIT / 2);
    localparam logic [PW-1:0]  LAST  = PW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]     LAST_BIT = 3'(UART_DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
    localparam rx_state_t ST_AFTER_DATA = ST_PARITY;
`else
    localparam rx_state_t ST_AFTER_DATA = ST_STOP;
`endif

    if (CLKS_PER_BIT < 8 || ODD_PARITY < 0 || ODD_PARITY > 1) begin : g_bad_config
        $error("uart_rx_engine: CLKS_PER_BIT must be >= 8 and ODD_PARITY must be 0 or 1");
    end

    rx_state_t                 state;
    logic [PW-1:0]             phase;
    logic [2:0]                bit_idx;
    logic [UART_DATA_BITS-1:0] shift;
    logic                      rxd_s;
    logic                      mid_bit;
    logic                      stop_sample;
    logic                      deliver;
    logic                      frame_bad;
    logic                      par_bad;

    uart_rx_sync #(
        .RESET_VAL (1'b1)
    ) u_rxd_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rxd),
        .q     (rxd_s)
    );

    assign mid_bit     = (phase == LAST);
    assign stop_sample = rx_enable && (state == ST_STOP) && mid_bit;
    assign deliver     = stop_sample && rxd_s;
    assign frame_bad   = stop_sample && !rxd_s;
    assign busy        = (state != ST_IDLE);

`ifdef UART_RX_PARITY_EN
    assign par_bad = rx_enable && (state == ST_PARITY) && mid_bit
                     && (rxd_s != parity_of(shift, ODD_PARITY[0]));
`else
    assign par_bad = 1'b0;
`endif

    // Frame recovery: start qualification, mid-bit data sampling, stop check, line-low hold-off
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            phase   <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else if (!rx_enable) begin
            state <= ST_IDLE;
            phase <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!rxd_s) begin
                        state <= ST_START;
                        phase <= '0;
                    end
                end
                ST_START: begin
                    if (phase == HALF) begin
                        phase   <= '0;
                        bit_idx <= '0;
                        state   <= rxd_s ? ST_IDLE : ST_DATA;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (mid_bit) begin
                        phase   <= '0;
                        shift   <= {rxd_s, shift[UART_DATA_BITS-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == LAST_BIT) begin
                            state <= ST_AFTER_DATA;
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                ST_PARITY: begin
`ifdef UART_RX_PARITY_EN
                    if (mid_bit) begin
                        phase <= '0;
                        state <= ST_STOP;
                    end else begin
                        phase <= phase + 1'b1;
                    end
`else
                    state <= ST_IDLE;
`endif
                end
                ST_STOP: begin
                    if (mid_bit) begin
                        phase <= '0;
                        state <= rxd_s ? ST_IDLE : ST_WAIT_IDLE;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (rxd_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    phase <= '0;
                end
            endcase
        end
    end

    // Output holding register, handshake and one-cycle error pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err  <= frame_bad;
            parity_err <= par_bad;
            overrun    <= 1'b0;
            if (deliver) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shift;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_engine.sv
// tb/tb_uart_rx_engine.sv - scoreboard bench for uart_rx_engine with randomized frames
`timescale 1ns/1ps
module tb_uart_rx_engine;

    localparam int CPB = 16;
    localparam int ODD = 0;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif
    // Fall of the start bit (first clock that samples it) to rx_valid high
    localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1 + PAR_EN * CPB;

    localparam int EV_DATA  = 0;
    localparam int EV_FRAME = 1;
    localparam int EV_PAR   = 2;
    localparam int EV_OVR   = 3;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rxd = 1'b1;
    logic       rx_enable = 1'b0;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;
    logic       busy;

    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;
    int  fall_cyc = 0;
    bit  held = 1'b0;
    ev_t exp_q[$];

    uart_rx_engine #(
        .CLKS_PER_BIT (CPB),
        .ODD_PARITY   (ODD)
    ) dut (
        .clk        (clk),
        .reset      (reset_n),
        .rxd        (rxd),
        .rx_enable  (rx_enable),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Parity bit a transmitter sends: makes the total count of ones even (or odd)
    function automatic bit model_parity(input logic [7:0] d);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return (ODD != 0) ? ((ones % 2) == 0) : ((ones % 2) == 1);
    endfunction

    task automatic push_ev(input int kind, input logic [7:0] d);
        ev_t e;
        e.kind = kind;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic drive_bit(input logic b);
        rxd = b;
        repeat (CPB) @(negedge clk);
    endtask

    // Sends one frame starting at the current negedge and predicts its outcome
    task automatic send_frame(input logic [7:0] d, input bit stop, input bit bad_par, input bit push);
        bit pbit;
        pbit = model_parity(d) ^ bad_par;
        if (push) begin
            if (PAR_EN != 0 && bad_par) push_ev(EV_PAR, d);
            if (!stop) push_ev(EV_FRAME, d);
            else if (held) push_ev(EV_OVR, d);
            else begin
                push_ev(EV_DATA, d);
                held = !rx_ready;
            end
        end
        fall_cyc = cyc + 1;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (PAR_EN != 0) drive_bit(pbit);
        drive_bit(stop);
    endtask

    task automatic expect_ev(input int kind, input logic [7:0] d, input bit cmp_data);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d data 0x%0h expected no event", kind, d);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", kind, e.kind);
            if (cmp_data && e.kind == kind) check("event_data", d, e.data);
        end
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 4 * CPB && exp_q.size() != 0; i++) @(negedge clk);
        check(name, exp_q.size(), 0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a byte or an error pulse
    initial begin : monitor
        bit         pv, pa, pfe, ppe, pov;
        logic [7:0] pd;
        pv = 0; pa = 0; pfe = 0; ppe = 0; pov = 0; pd = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                pv = 0; pa = 0; pfe = 0; ppe = 0; pov = 0;
            end else begin
                if (pfe) check("frame_err_width", frame_err, 1'b0);
                if (ppe) check("parity_err_width", parity_err, 1'b0);
                if (pov) check("overrun_width", overrun, 1'b0);
                if (parity_err) expect_ev(EV_PAR, rx_data, 1'b0);
                if (frame_err) expect_ev(EV_FRAME, rx_data, 1'b0);
                if (overrun) expect_ev(EV_OVR, rx_data, 1'b0);
                if (rx_valid && (!pv || pa)) expect_ev(EV_DATA, rx_data, 1'b1);
                else if (rx_valid && pv) check("rx_data_hold", rx_data, pd);
                pv  = rx_valid;
                pa  = rx_valid && rx_ready;
                pd  = rx_data;
                pfe = frame_err;
                ppe = parity_err;
                pov = overrun;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : stimulus
        logic [7:0] rd;
        logic [7:0] part;
        bit         rstop, rbad, seen;
        int         gap;

        repeat (3) @(negedge clk);
        check("reset_rx_valid", rx_valid, 1'b0);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_errs", {frame_err, parity_err, overrun}, 3'b000);
        check("reset_busy", busy, 1'b0);
        reset_n = 1'b1;
        rx_enable = 1'b1;
        repeat (4) @(negedge clk);

        // 0xA5 with ready held high: latency and single-cycle valid
        seen = 1'b0;
        fork
            send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
            begin
                for (int i = 0; i < LAT + 40 && !seen; i++) begin
                    @(negedge clk);
                    if (rx_valid) seen = 1'b1;
                end
                check("a5_seen", seen, 1'b1);
                check("a5_latency", cyc - fall_cyc, LAT);
                check("a5_data", rx_data, 8'hA5);
                @(negedge clk);
                check("a5_valid_one_cycle", rx_valid, 1'b0);
            end
        join
        wait_drain("a5_drain");

        // Short low glitch is rejected as a false start
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        check("glitch_busy", busy, 1'b1);
        rxd = 1'b1;
        repeat (10) @(negedge clk);
        check("glitch_idle", busy, 1'b0);
        check("glitch_no_valid", rx_valid, 1'b0);

        // Stop bit low: frame error, then hold-off while the line stays low
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        repeat (3 * CPB) @(negedge clk);
        check("wait_idle_busy", busy, 1'b1);
        check("frame_no_valid", rx_valid, 1'b0);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
        check("wait_idle_exit", busy, 1'b0);
        wait_drain("frame_drain");
        repeat (CPB) @(negedge clk);

        // Back-to-back bytes with no consumer: second byte overruns
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0, 1'b1);
        send_frame(8'h22, 1'b1, 1'b0, 1'b1);
        wait_drain("ovr_drain");
        check("ovr_data", rx_data, 8'h11);
        check("ovr_valid", rx_valid, 1'b1);
        rx_ready = 1'b1;
        held = 1'b0;
        repeat (2) @(negedge clk);
        check("ovr_clear", rx_valid, 1'b0);

`ifdef UART_RX_PARITY_EN
        // Wrong parity bit: error pulse but byte still delivered
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        wait_drain("par_drain");
        check("par_data", rx_data, 8'h07);
`endif

        // Enable dropped mid-frame: silent abort
        fork
            send_frame(8'h96, 1'b1, 1'b0, 1'b0);
            begin
                repeat (4 * CPB) @(negedge clk);
                check("abort_busy_before", busy, 1'b1);
                rx_enable = 1'b0;
                @(negedge clk);
                check("abort_busy", busy, 1'b0);
            end
        join
        repeat (2 * CPB) @(negedge clk);
        rx_enable = 1'b1;
        repeat (4) @(negedge clk);
        check("abort_no_valid", rx_valid, 1'b0);

        // Reset in data bit 4 while a byte is held
        rx_ready = 1'b0;
        send_frame(8'hC3, 1'b1, 1'b0, 1'b1);
        wait_drain("hold_drain");
        check("hold_valid", rx_valid, 1'b1);
        part = 8'hF0;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(part[i]);
        rxd = part[4];
        repeat (CPB / 2) @(negedge clk);
        check("rst_busy_before", busy, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_errs", {frame_err, parity_err, overrun}, 3'b000);
        @(negedge clk);
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        held = 1'b0;
        rx_ready = 1'b1;
        repeat (CPB) @(negedge clk);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b1);
        wait_drain("rst_5a_drain");
        check("rst_5a_data", rx_data, 8'h5A);

        // Randomized frames, occasional bad stop/parity, some back-to-back
        for (int n = 0; n < 16; n++) begin
            rd    = 8'($urandom_range(0, 255));
            rstop = ($urandom_range(0, 7) != 0);
            rbad  = ($urandom_range(0, 3) == 0);
            gap   = rstop ? int'($urandom_range(0, 2)) : CPB;
            send_frame(rd, rstop, rbad, 1'b1);
            rxd = 1'b1;
            repeat (gap) @(negedge clk);
        end
        wait_drain("random_drain");
        repeat (CPB) @(negedge clk);
        check("final_busy", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
